// File: rtl/box_march_worker_pkg.sv
// Fixed-point package shared by the box-march pixel worker.
// Provides the Q(BITS-FRAC).FRAC number type, conversion and magnitude helpers,
// and the march FSM state encoding.
package box_march_worker_pkg;

  localparam int BITS = 32;
  localparam int FRAC = 16;

  typedef logic signed [BITS-1:0] fx_t;

  localparam fx_t FX_MAX = fx_t'({1'b0, {(BITS-1){1'b1}}});
  localparam fx_t FX_MIN = fx_t'({1'b1, {(BITS-1){1'b0}}});

  typedef enum logic [2:0] {
    IDLE,
    SETUP1,
    SETUP2,
    DIST,
    STEP,
    SHADE
  } march_state_t;

  function automatic fx_t to_fixed(input int value);
    return fx_t'(value) <<< FRAC;
  endfunction

  // The most negative value has no positive twin, so it saturates instead of wrapping.
  function automatic fx_t fx_abs(input fx_t x);
    if (x == FX_MIN) return FX_MAX;
    return (x < 0) ? -x : x;
  endfunction

  function automatic fx_t fx_max3(input fx_t a, input fx_t b, input fx_t c);
    fx_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/box_sdf_eval.sv
// Combinational Chebyshev distance from point p to an origin-centred cube.
// Ports:
//   i_px, i_py, i_pz  point coordinates, fixed point
//   i_half            cube half-extent, fixed point
//   o_dist            max(|px|,|py|,|pz|) - half (negative inside the cube)
module box_sdf_eval
  import box_march_worker_pkg::*;
(
  input  fx_t i_px,
  input  fx_t i_py,
  input  fx_t i_pz,
  input  fx_t i_half,
  output fx_t o_dist
);

  assign o_dist = fx_max3(fx_abs(i_px), fx_abs(i_py), fx_abs(i_pz)) - i_half;

endmodule

// File: rtl/box_march_worker.sv
// Pixel worker: takes one pixel job, sphere-traces its ray against a cube and
// returns a one-cycle done strobe with the pixel coordinates and a greyscale colour.
// Pixel (0,0) is started internally after each reset because the dispatcher only
// issues start_in for later pixels.
// Ports:
//   clk_in, rst_in         clock, asynchronous active-high reset
//   start_in               one-cycle job strobe, honoured only in IDLE
//   curr_x, curr_y         job pixel
//   timer                  frame counter, latched but not used for shading
//   camera_*               ray origin, screen basis u/v and image-plane offset
//   pixel_done             one-cycle result strobe
//   color_out, out_x/out_y result colour and pixel, valid with pixel_done
//   busy                   high whenever the FSM is not in IDLE
module box_march_worker
  import box_march_worker_pkg::*;
#(
  parameter int  WIDTH     = 1280,
  parameter int  HEIGHT    = 720,
  parameter int  MAX_STEPS = 32,
  parameter fx_t BOX_HALF  = to_fixed(32),
  parameter fx_t HIT_EPS   = fx_t'(1 <<< 12),
  parameter fx_t FAR       = to_fixed(1024),
  parameter int  DIR_SHIFT = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [$clog2(WIDTH)-1:0]  curr_x,
  input  logic [$clog2(HEIGHT)-1:0] curr_y,
  input  logic [31:0]               timer,
  input  fx_t                       camera_x,
  input  fx_t                       camera_y,
  input  fx_t                       camera_z,
  input  fx_t                       camera_u_x,
  input  fx_t                       camera_u_y,
  input  fx_t                       camera_u_z,
  input  fx_t                       camera_v_x,
  input  fx_t                       camera_v_y,
  input  fx_t                       camera_v_z,
  input  fx_t                       camera_forward_x,
  input  fx_t                       camera_forward_y,
  input  fx_t                       camera_forward_z,
  output logic                      pixel_done,
  output logic [7:0]                color_out,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output logic                      busy
);

  localparam int XW      = $clog2(WIDTH);
  localparam int YW      = $clog2(HEIGHT);
  localparam int STEPS_W = $clog2(MAX_STEPS + 1);
  localparam int SHIFT   = FRAC + DIR_SHIFT;

  march_state_t r_state, w_nextState;

  logic               r_autoPending;
  logic [XW-1:0]      r_currX, r_outX;
  logic [YW-1:0]      r_currY, r_outY;
  logic [31:0]        r_timer;
  logic [STEPS_W-1:0] r_steps;
  logic               r_pixelDone;
  logic [7:0]         r_color;

  fx_t r_cam [3];
  fx_t r_u   [3];
  fx_t r_v   [3];
  fx_t r_fwd [3];
  fx_t r_usx [3];
  fx_t r_dir [3];
  fx_t r_p   [3];

  fx_t                      w_sx, w_sy, w_dist, w_opB;
  fx_t                      w_opA  [3];
  logic signed [2*BITS-1:0] w_prod [3];
  logic                     w_start, w_hit, w_far, w_unusedTimer;
  logic [7:0]               w_shade;

  box_sdf_eval u_sdf (
    .i_px   (r_p[0]),
    .i_py   (r_p[1]),
    .i_pz   (r_p[2]),
    .i_half (BOX_HALF),
    .o_dist (w_dist)
  );

  assign w_start       = start_in || r_autoPending;
  assign w_sx          = fx_t'(r_currX) - fx_t'(WIDTH / 2);
  assign w_sy          = fx_t'(HEIGHT / 2) - fx_t'(r_currY);
  assign w_hit         = (w_dist < HIT_EPS);
  assign w_far         = (fx_abs(r_p[0]) > FAR) || (fx_abs(r_p[1]) > FAR) || (fx_abs(r_p[2]) > FAR);
  assign w_unusedTimer = ^r_timer;

  assign pixel_done = r_pixelDone;
  assign color_out  = r_color;
  assign out_x      = r_outX;
  assign out_y      = r_outY;
  assign busy       = (r_state != IDLE);

  // Brightness falls by 8 per march step and clamps at black.
  always_comb begin
    w_shade = 8'd0;
    if (int'(r_steps) * 8 <= 255) w_shade = 8'(255 - int'(r_steps) * 8);
  end

  // One bank of three multipliers: u*sx in SETUP1, v*sy in SETUP2, dir*d in STEP.
  always_comb begin
    w_opB = w_dist;
    for (int i = 0; i < 3; i++) w_opA[i] = r_dir[i];
    case (r_state)
      SETUP1: begin
        w_opB = w_sx;
        for (int i = 0; i < 3; i++) w_opA[i] = r_u[i];
      end
      SETUP2: begin
        w_opB = w_sy;
        for (int i = 0; i < 3; i++) w_opA[i] = r_v[i];
      end
      default: ;
    endcase
    for (int i = 0; i < 3; i++) w_prod[i] = (2*BITS)'(w_opA[i]) * (2*BITS)'(w_opB);
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; a hit takes priority over the step limit and escape test.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = SETUP1;
      SETUP1:  w_nextState = SETUP2;
      SETUP2:  w_nextState = DIST;
      DIST: begin
        if (w_hit)                                               w_nextState = SHADE;
        else if ((r_steps == STEPS_W'(MAX_STEPS)) || w_far)      w_nextState = SHADE;
        else                                                     w_nextState = STEP;
      end
      STEP:    w_nextState = DIST;
      SHADE:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: job latch, ray setup, marching and result registers.
  // The auto-start job ignores curr_x/curr_y and always renders (0,0).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_autoPending <= 1'b1;
      r_pixelDone   <= 1'b0;
      r_color       <= '0;
      r_outX        <= '0;
      r_outY        <= '0;
      r_currX       <= '0;
      r_currY       <= '0;
      r_timer       <= '0;
      r_steps       <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cam[i] <= '0;
        r_u[i]   <= '0;
        r_v[i]   <= '0;
        r_fwd[i] <= '0;
        r_usx[i] <= '0;
        r_dir[i] <= '0;
        r_p[i]   <= '0;
      end
    end else begin
      r_pixelDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_autoPending <= 1'b0;
            r_currX       <= r_autoPending ? '0 : curr_x;
            r_currY       <= r_autoPending ? '0 : curr_y;
            r_timer       <= timer;
            r_cam[0] <= camera_x;         r_cam[1] <= camera_y;         r_cam[2] <= camera_z;
            r_u[0]   <= camera_u_x;       r_u[1]   <= camera_u_y;       r_u[2]   <= camera_u_z;
            r_v[0]   <= camera_v_x;       r_v[1]   <= camera_v_y;       r_v[2]   <= camera_v_z;
            r_fwd[0] <= camera_forward_x; r_fwd[1] <= camera_forward_y; r_fwd[2] <= camera_forward_z;
          end
        end
        SETUP1: begin
          for (int i = 0; i < 3; i++) r_usx[i] <= fx_t'(w_prod[i]);
        end
        SETUP2: begin
          for (int i = 0; i < 3; i++) begin
            r_dir[i] <= r_fwd[i] + r_usx[i] + fx_t'(w_prod[i]);
            r_p[i]   <= r_cam[i];
          end
          r_steps <= '0;
        end
        STEP: begin
          for (int i = 0; i < 3; i++) r_p[i] <= r_p[i] + fx_t'(w_prod[i] >>> SHIFT);
          r_steps <= r_steps + STEPS_W'(1);
        end
        SHADE: begin
          r_pixelDone <= 1'b1;
          r_color     <= w_hit ? w_shade : 8'd0;
          r_outX      <= r_currX;
          r_outY      <= r_currY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_box_march_worker.sv
// Directed bench for the box-march pixel worker: auto-start after reset, a centre
// hit, an inside-cube camera, ignored starts while busy, reset during marching and
// a renderer-style walk over a small frame.
module tb_box_march_worker;
  import box_march_worker_pkg::*;

  logic        clk = 1'b0;
  logic        rstIn, startIn;
  logic [10:0] currX;
  logic [9:0]  currY;
  logic [31:0] timer;
  fx_t         camX, camY, camZ, uX, uY, uZ, vX, vY, vZ, fwdX, fwdY, fwdZ;
  logic        pixelDone, busy;
  logic [7:0]  colorOut;
  logic [10:0] outX;
  logic [9:0]  outY;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  box_march_worker dut (
    .clk_in           (clk),
    .rst_in           (rstIn),
    .start_in         (startIn),
    .curr_x           (currX),
    .curr_y           (currY),
    .timer            (timer),
    .camera_x         (camX),
    .camera_y         (camY),
    .camera_z         (camZ),
    .camera_u_x       (uX),
    .camera_u_y       (uY),
    .camera_u_z       (uZ),
    .camera_v_x       (vX),
    .camera_v_y       (vY),
    .camera_v_z       (vZ),
    .camera_forward_x (fwdX),
    .camera_forward_y (fwdY),
    .camera_forward_z (fwdZ),
    .pixel_done       (pixelDone),
    .color_out        (colorOut),
    .out_x            (outX),
    .out_y            (outY),
    .busy             (busy)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Drive a one-cycle start strobe from the current negedge; returns at the next
  // negedge, which lies in the first cycle after the start was sampled.
  task automatic applyStimulus(input int x, input int y);
    currX   = 11'(x);
    currY   = 10'(y);
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
  endtask

  // Latency k counts cycles after the start-sampling edge (k=1 at the first call).
  task automatic waitDone(input int limit, output int latency, output bit got);
    got     = 1'b0;
    latency = 0;
    for (int k = 1; k <= limit; k++) begin
      if (pixelDone) begin
        got     = 1'b1;
        latency = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic setCommonCamera();
    camX = '0;  camY = '0;           camZ = to_fixed(150);
    uX   = to_fixed(1); uY = '0;     uZ   = '0;
    vX   = '0;  vY = to_fixed(1);    vZ   = '0;
    fwdX = '0;  fwdY = '0;           fwdZ = to_fixed(-150);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  got;
    int  extra;
    bit  sawDone;

    rstIn   = 1'b1;
    startIn = 1'b0;
    currX   = '0;
    currY   = '0;
    timer   = 32'd7;
    setCommonCamera();

    // Test 1: reset state, then the self-started (0,0) job misses.
    repeat (3) @(negedge clk);
    checkOutput("rst pixel_done", int'(pixelDone), 0);
    checkOutput("rst color",      int'(colorOut), 0);
    checkOutput("rst out_x",      int'(outX), 0);
    checkOutput("rst out_y",      int'(outY), 0);
    checkOutput("rst busy",       int'(busy), 0);
    rstIn = 1'b0;
    waitDone(200, lat, got);
    checkOutput("auto done seen", int'(got), 1);
    checkOutput("auto out_x",     int'(outX), 0);
    checkOutput("auto out_y",     int'(outY), 0);
    checkOutput("auto color",     int'(colorOut), 0);
    @(negedge clk);
    checkOutput("auto done width", int'(pixelDone), 0);
    checkOutput("auto busy after", int'(busy), 0);

    // Test 2: centre pixel hits the cube after 8..12 steps.
    applyStimulus(640, 360);
    waitDone(200, lat, got);
    checkOutput("centre done seen",   int'(got), 1);
    checkOutput("centre out_x",       int'(outX), 640);
    checkOutput("centre out_y",       int'(outY), 360);
    checkOutput("centre color range", int'(colorOut >= 159 && colorOut <= 191), 1);
    checkOutput("centre color step",  (255 - int'(colorOut)) % 8, 0);
    checkOutput("centre latency range", int'(lat >= 21 && lat <= 29), 1);
    @(negedge clk);
    checkOutput("centre done width", int'(pixelDone), 0);
    checkOutput("centre busy after", int'(busy), 0);

    // Test 3: camera inside the cube hits immediately with full brightness.
    camZ = '0;
    applyStimulus(100, 200);
    waitDone(40, lat, got);
    checkOutput("inside done seen", int'(got), 1);
    checkOutput("inside latency",   lat, 5);
    checkOutput("inside color",     int'(colorOut), 255);
    checkOutput("inside out_x",     int'(outX), 100);
    checkOutput("inside out_y",     int'(outY), 200);
    @(negedge clk);
    setCommonCamera();

    // Test 4: a start while busy is neither taken nor queued.
    applyStimulus(640, 360);
    repeat (2) @(negedge clk);
    checkOutput("busy while marching", int'(busy), 1);
    currX   = 11'd5;
    currY   = 10'd7;
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    waitDone(200, lat, got);
    checkOutput("ignore done seen",   int'(got), 1);
    checkOutput("ignore out_x",       int'(outX), 640);
    checkOutput("ignore out_y",       int'(outY), 360);
    checkOutput("ignore color range", int'(colorOut >= 159 && colorOut <= 191), 1);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (pixelDone) extra++;
    end
    checkOutput("ignore extra dones", extra, 0);
    checkOutput("ignore busy after",  int'(busy), 0);

    // Test 5: reset in the middle of marching clears outputs and drops the job.
    applyStimulus(640, 360);
    repeat (5) @(negedge clk);
    rstIn = 1'b1;
    #1;
    checkOutput("midrst pixel_done", int'(pixelDone), 0);
    checkOutput("midrst color",      int'(colorOut), 0);
    checkOutput("midrst out_x",      int'(outX), 0);
    checkOutput("midrst out_y",      int'(outY), 0);
    checkOutput("midrst busy",       int'(busy), 0);
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pixelDone) sawDone = 1'b1;
    end
    checkOutput("midrst no stale done", int'(sawDone), 0);
    rstIn = 1'b0;
    waitDone(200, lat, got);
    checkOutput("midrst auto done seen", int'(got), 1);
    checkOutput("midrst auto out_x",     int'(outX), 0);
    checkOutput("midrst auto out_y",     int'(outY), 0);
    checkOutput("midrst auto color",     int'(colorOut), 0);
    @(negedge clk);

    // Test 6: renderer walks a 4x2 frame, restarting one cycle after each done.
    rstIn = 1'b1;
    @(negedge clk);
    rstIn = 1'b0;
    for (int idx = 0; idx < 8; idx++) begin
      waitDone(200, lat, got);
      checkOutput($sformatf("walk%0d done seen", idx), int'(got), 1);
      checkOutput($sformatf("walk%0d out_x", idx), int'(outX), idx % 4);
      checkOutput($sformatf("walk%0d out_y", idx), int'(outY), idx / 4);
      @(negedge clk);
      checkOutput($sformatf("walk%0d done width", idx), int'(pixelDone), 0);
      if (idx < 7) applyStimulus((idx + 1) % 4, (idx + 1) / 4);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
